// File: rtl/uart_pkg.sv
// Shared register map, status/control bit positions and FSM encodings for the buffered UART.
package uart_pkg;

    localparam logic [3:0] ADDR_DATA = 4'h0;
    localparam logic [3:0] ADDR_STAT = 4'h4;
    localparam logic [3:0] ADDR_CTRL = 4'h8;
    localparam logic [3:0] ADDR_BAUD = 4'hC;

    localparam int ST_TX_BUSY    = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVR     = 4;
    localparam int ST_FRAME_ERR  = 5;
    localparam int ST_PARITY_ERR = 6;
    localparam int ST_TX_OVF     = 7;

    localparam int CTRL_PAR_EN   = 0;
    localparam int CTRL_PAR_ODD  = 1;
    localparam int CTRL_TWO_STOP = 2;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; a push while full is dropped even if a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, runtime baud divisor, optional parity, 1/2 stop bits,
// a 16x-oversampling receiver and a level RX interrupt.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        tx,
    input  logic        rx
);

    localparam logic [15:0] BAUD_RST = 16'(CLK_FREQ / (BAUD_RATE * 16));
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]  ctrl_q;
    logic [15:0] baud_q, baud_eff, tick_cnt_q;
    logic        tick;
    logic [7:4]  sticky_q, sticky_d, sticky_set;

    logic        data_wr, stat_wr, ctrl_wr, baud_wr, data_rd;
    logic        tx_full, tx_empty, tx_pop;
    logic [7:0]  tx_dout;
    logic        rx_full, rx_empty;
    logic [7:0]  rx_dout;
    logic [CW-1:0] tx_count, rx_count;
    logic        unused_ok;

    tx_state_e   tx_state_q;
    logic        tx_pend_q, tx_q, tx_par_q, tx_pen_q, tx_two_q;
    logic [4:0]  tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_sh_q;
    logic        tx_busy;

    rx_state_e   rx_state_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_pen_q, rx_odd_q;
    logic [3:0]  rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_sh_q;
    logic        rx_push_q, rx_ferr_q, rx_perr_q;

    assign data_wr = we && (addr == ADDR_DATA);
    assign stat_wr = we && (addr == ADDR_STAT);
    assign ctrl_wr = we && (addr == ADDR_CTRL);
    assign baud_wr = we && (addr == ADDR_BAUD);
    assign data_rd = re && (addr == ADDR_DATA);

    assign unused_ok = ^{tx_count, rx_count, wdata[31:16]};

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(data_wr), .din_i(wdata[7:0]), .pop_i(tx_pop),
        .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push_q), .din_i(rx_sh_q), .pop_i(data_rd),
        .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
    );

    // Shared 16x tick; a divisor of 0 behaves as 1.
    assign baud_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;
    assign tick     = (tick_cnt_q >= baud_eff - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || baud_wr || tick) tick_cnt_q <= 16'd0;
        else                        tick_cnt_q <= tick_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= 3'd0;
            baud_q <= BAUD_RST;
        end else begin
            if (ctrl_wr) ctrl_q <= wdata[2:0];
            if (baud_wr) baud_q <= wdata[15:0];
        end
    end

    always_comb begin
        sticky_set                = '0;
        sticky_set[ST_RX_OVR]     = rx_push_q && rx_full;
        sticky_set[ST_FRAME_ERR]  = rx_ferr_q;
        sticky_set[ST_PARITY_ERR] = rx_perr_q;
        sticky_set[ST_TX_OVF]     = data_wr && tx_full;
        sticky_d = (sticky_q & ~(stat_wr ? wdata[7:4] : 4'h0)) | sticky_set;
    end

    always_ff @(posedge clk) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end

    // Pop either from IDLE (then wait for the next tick) or at the end of STOP for back-to-back frames.
    always_comb begin
        tx_pop = 1'b0;
        if (!tx_empty) begin
            if (tx_state_q == TX_IDLE && !tx_pend_q)
                tx_pop = 1'b1;
            else if (tx_state_q == TX_STOP && tick && tx_cnt_q == (tx_two_q ? 5'd31 : 5'd15))
                tx_pop = 1'b1;
        end
    end

    assign tx_busy = !tx_empty || (tx_state_q != TX_IDLE) || tx_pend_q;
    assign tx      = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_pend_q  <= 1'b0;
            tx_cnt_q   <= 5'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_two_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            if (tx_pop) begin
                tx_sh_q  <= tx_dout;
                tx_par_q <= (^tx_dout) ^ ctrl_q[CTRL_PAR_ODD];
                tx_pen_q <= ctrl_q[CTRL_PAR_EN];
                tx_two_q <= ctrl_q[CTRL_TWO_STOP];
            end
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pend_q) begin
                        if (tick) begin
                            tx_pend_q  <= 1'b0;
                            tx_state_q <= TX_START;
                            tx_cnt_q   <= 5'd0;
                            tx_q       <= 1'b0;
                        end
                    end else if (tx_pop) begin
                        tx_pend_q <= 1'b1;
                    end
                end
                TX_START: if (tick) begin
                    if (tx_cnt_q == 5'd15) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= 5'd0;
                        tx_bit_q   <= 3'd0;
                        tx_q       <= tx_sh_q[0];
                    end else tx_cnt_q <= tx_cnt_q + 5'd1;
                end
                TX_DATA: if (tick) begin
                    if (tx_cnt_q == 5'd15) begin
                        tx_cnt_q <= 5'd0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= tx_pen_q ? TX_PARITY : TX_STOP;
                            tx_q       <= tx_pen_q ? tx_par_q : 1'b1;
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            tx_q     <= tx_sh_q[1];
                        end
                    end else tx_cnt_q <= tx_cnt_q + 5'd1;
                end
                TX_PARITY: if (tick) begin
                    if (tx_cnt_q == 5'd15) begin
                        tx_state_q <= TX_STOP;
                        tx_cnt_q   <= 5'd0;
                        tx_q       <= 1'b1;
                    end else tx_cnt_q <= tx_cnt_q + 5'd1;
                end
                TX_STOP: if (tick) begin
                    if (tx_cnt_q == (tx_two_q ? 5'd31 : 5'd15)) begin
                        tx_cnt_q <= 5'd0;
                        if (tx_pop) begin
                            tx_state_q <= TX_START;
                            tx_q       <= 1'b0;
                        end else tx_state_q <= TX_IDLE;
                    end else tx_cnt_q <= tx_cnt_q + 5'd1;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // Receiver: start check at tick 8, then every 16 ticks lands on a bit midpoint.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_pen_q   <= 1'b0;
            rx_odd_q   <= 1'b0;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            rx_perr_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                    rx_state_q <= RX_START;
                    rx_cnt_q   <= 4'd0;
                    rx_pen_q   <= ctrl_q[CTRL_PAR_EN];
                    rx_odd_q   <= ctrl_q[CTRL_PAR_ODD];
                end
                RX_START: if (tick) begin
                    if (rx_cnt_q == 4'd7) begin
                        rx_cnt_q   <= 4'd0;
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else rx_cnt_q <= rx_cnt_q + 4'd1;
                end
                RX_DATA: if (tick) begin
                    rx_cnt_q <= rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= rx_pen_q ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: if (tick) begin
                    rx_cnt_q <= rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        rx_state_q <= RX_STOP;
                        rx_perr_q  <= rx_s2_q != ((^rx_sh_q) ^ rx_odd_q);
                    end
                end
                RX_STOP: if (tick) begin
                    rx_cnt_q <= rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        rx_state_q <= RX_IDLE;
                        rx_push_q  <= rx_s2_q;
                        rx_ferr_q  <= !rx_s2_q;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign irq = !rx_empty;

    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_DATA: rdata[7:0] = rx_empty ? 8'd0 : rx_dout;
            ADDR_STAT: begin
                rdata[ST_TX_BUSY]  = tx_busy;
                rdata[ST_TX_FULL]  = tx_full;
                rdata[ST_RX_VALID] = !rx_empty;
                rdata[ST_RX_FULL]  = rx_full;
                rdata[7:4]         = sticky_q;
            end
            ADDR_CTRL: rdata[2:0]  = ctrl_q;
            ADDR_BAUD: rdata[15:0] = baud_q;
            default:   rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench: TX frame table, loopback RX table, and hand-driven RX corner cases.
module tb_uart_fifo;

    localparam logic [3:0] A_DATA = 4'h0;
    localparam logic [3:0] A_STAT = 4'h4;
    localparam logic [3:0] A_CTRL = 4'h8;
    localparam logic [3:0] A_BAUD = 4'hC;

    logic        clk = 1'b0;
    logic        rst, we, re, irq, tx, rx_drv, loop;
    logic [3:0]  addr;
    logic [31:0] wdata, rdata;
    logic        rx_w;

    int n_pass  = 0;
    int n_total = 0;

    assign rx_w = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo #(.CLK_FREQ(100000000), .BAUD_RATE(115200), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata), .irq(irq), .tx(tx), .rx(rx_w)
    );

    typedef struct {
        logic [7:0]  din;
        logic [2:0]  ctrl;
        int          nbits;
        logic [31:0] exp;
    } txv_t;

    typedef struct {
        logic [7:0] din;
        logic [2:0] ctrl;
    } rxv_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic pop, output logic [31:0] d);
        @(negedge clk);
        addr = a; re = pop;
        #1 d = rdata;
        @(negedge clk);
        re = 1'b0;
    endtask

    // Wait for a start bit, then sample each bit at its midpoint (BAUD=4 -> 64 cycles/bit).
    task automatic capture(input int nbits, output logic [31:0] bits, output int low_len);
        bit found;
        found   = 1'b0;
        bits    = '0;
        low_len = -1;
        for (int w = 0; w < 4000 && !found; w++) begin
            @(negedge clk);
            if (tx == 1'b0) found = 1'b1;
        end
        chk("tx_start_seen", 32'(found), 32'd1);
        if (found) begin
            for (int c = 0; c < nbits * 64; c++) begin
                if (c % 64 == 32) bits[c / 64] = tx;
                if (tx && low_len < 0) low_len = c;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_irq(input string nm);
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 3000 && !seen; w++) begin
            @(negedge clk);
            if (irq) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stopb);
        rx_drv = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (64) @(negedge clk);
        end
        if (pen) begin
            rx_drv = pbit;
            repeat (64) @(negedge clk);
        end
        rx_drv = stopb;
        repeat (64) @(negedge clk);
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    initial begin
        txv_t        tv[6];
        rxv_t        rv[4];
        logic [31:0] v, bits;
        int          low_len;

        tv[0] = '{8'h55, 3'd0, 10, {22'h0, 1'b1, 8'h55, 1'b0}};
        tv[1] = '{8'h01, 3'd3, 11, {21'h0, 1'b1, 1'b0, 8'h01, 1'b0}};
        tv[2] = '{8'h01, 3'd1, 11, {21'h0, 1'b1, 1'b1, 8'h01, 1'b0}};
        tv[3] = '{8'hA5, 3'd4, 11, {21'h0, 1'b1, 1'b1, 8'hA5, 1'b0}};
        tv[4] = '{8'h80, 3'd1, 11, {21'h0, 1'b1, 1'b1, 8'h80, 1'b0}};
        tv[5] = '{8'h00, 3'd3, 11, {21'h0, 1'b1, 1'b1, 8'h00, 1'b0}};

        rv[0] = '{8'h5A, 3'd0};
        rv[1] = '{8'hC3, 3'd1};
        rv[2] = '{8'h7E, 3'd3};
        rv[3] = '{8'h00, 3'd4};

        rst = 1'b1; we = 1'b0; re = 1'b0; addr = 4'h0; wdata = 32'h0;
        rx_drv = 1'b1; loop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_irq", 32'(irq), 32'd0);
        rd(A_STAT, 1'b0, v); chk("reset_stat", v, 32'h0);
        rd(A_CTRL, 1'b0, v); chk("reset_ctrl", v, 32'h0);
        rd(A_BAUD, 1'b0, v); chk("reset_baud", v, 32'd54);
        rd(A_DATA, 1'b0, v); chk("reset_data", v, 32'h0);
        rd(4'h2, 1'b0, v);   chk("unmapped_read", v, 32'h0);

        wr(A_BAUD, 32'd4);
        for (int i = 0; i < 6; i++) begin
            wr(A_CTRL, 32'(tv[i].ctrl));
            wr(A_DATA, 32'(tv[i].din));
            capture(tv[i].nbits, bits, low_len);
            chk($sformatf("tx_frame[%0d]", i), bits, tv[i].exp);
            if (i == 0) chk("tx_bit_len", 32'(low_len), 32'd64);
        end

        // Three frames back-to-back, no idle gap
        wr(A_CTRL, 32'd0);
        wr(A_DATA, 32'hA5);
        wr(A_DATA, 32'h3C);
        wr(A_DATA, 32'hFF);
        rd(A_STAT, 1'b0, v); chk("b2b_busy", 32'(v[0]), 32'd1);
        capture(30, bits, low_len);
        chk("b2b_frames", bits, {2'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0});
        repeat (8) @(negedge clk);
        rd(A_STAT, 1'b0, v); chk("b2b_idle", 32'(v[0]), 32'd0);

        // Two stop bits: next start must follow 2 full stop bits
        wr(A_CTRL, 32'd4);
        wr(A_DATA, 32'h00);
        wr(A_DATA, 32'h81);
        capture(22, bits, low_len);
        chk("two_stop_b2b", bits, {10'h0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0});
        repeat (80) @(negedge clk);

        // Loopback receive table
        loop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr(A_CTRL, 32'(rv[i].ctrl));
            wr(A_DATA, 32'(rv[i].din));
            wait_irq($sformatf("rx_irq[%0d]", i));
            rd(A_STAT, 1'b0, v);
            chk($sformatf("rx_stat[%0d]", i), 32'(v[7:2]), 32'd1);
            rd(A_DATA, 1'b1, v);
            chk($sformatf("rx_data[%0d]", i), v, 32'(rv[i].din));
            chk($sformatf("rx_irq_clr[%0d]", i), 32'(irq), 32'd0);
            repeat (200) @(negedge clk);
        end
        loop = 1'b0;

        // Framing error: byte discarded, W1C clears the bit
        wr(A_CTRL, 32'd0);
        drive_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        rd(A_STAT, 1'b0, v); chk("frame_err_stat", v, 32'h20);
        chk("frame_err_irq", 32'(irq), 32'd0);
        wr(A_STAT, 32'h20);
        rd(A_STAT, 1'b0, v); chk("frame_err_w1c", v, 32'h0);

        // Parity error: flagged but byte still delivered
        wr(A_CTRL, 32'd1);
        drive_frame(8'h01, 1'b1, 1'b0, 1'b1);
        rd(A_STAT, 1'b0, v); chk("parity_err_stat", v, 32'h44);
        rd(A_DATA, 1'b1, v); chk("parity_err_data", v, 32'h01);
        wr(A_STAT, 32'h40);
        rd(A_STAT, 1'b0, v); chk("parity_err_w1c", v, 32'h0);

        // Short low pulse must be rejected as a glitch
        wr(A_CTRL, 32'd0);
        @(negedge clk); rx_drv = 1'b0;
        repeat (12) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        rd(A_STAT, 1'b0, v); chk("glitch_reject", v, 32'h0);

        // RX overflow: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) drive_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        rd(A_STAT, 1'b0, v); chk("rx_ovr_stat", v, 32'h1C);
        for (int i = 0; i < 16; i++) begin
            rd(A_DATA, 1'b1, v);
            chk($sformatf("rx_ovr_data[%0d]", i), v, 32'h10 + 32'(i));
        end
        rd(A_STAT, 1'b0, v); chk("rx_ovr_drained", v, 32'h10);
        rd(A_DATA, 1'b1, v); chk("rx_empty_read", v, 32'h0);

        // TX overflow, then reset in the middle of the start bit
        for (int i = 0; i < 18; i++) wr(A_DATA, 32'(i));
        rd(A_STAT, 1'b0, v); chk("tx_ovf_stat", v, 32'h93);
        chk("tx_low_before_rst", 32'(tx), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); chk("tx_high_after_rst", 32'(tx), 32'd1);
        rst = 1'b0;
        rd(A_STAT, 1'b0, v); chk("post_rst_stat", v, 32'h0);
        rd(A_BAUD, 1'b0, v); chk("post_rst_baud", v, 32'd54);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
